// File: rtl/dmx_tx_csr.sv
// DMX512 transmitter with CSR-mapped control/status registers and a 512-byte universe buffer.
// Optional DMX_TX_IRQ_EN adds a sticky frame-done flag and a level IRQ output.
module dmx_tx_csr #(
  parameter int CLK_DIV    = 400,
  parameter int BREAK_BITS = 22,
  parameter int MAB_BITS   = 3
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [13:0] CSR_A,
  input  logic        CSR_WE,
  input  logic [31:0] CSR_DW,
  output logic [31:0] CSR_DR,
  output logic        DMX_TX,
  output logic        DMX_DE
`ifdef DMX_TX_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int CW = $clog2(CLK_DIV * BREAK_BITS);
  localparam logic [CW-1:0] BRK_LAST = CW'(BREAK_BITS * CLK_DIV - 1);
  localparam logic [CW-1:0] MAB_LAST = CW'(MAB_BITS * CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BREAK = 2'd1;
  localparam logic [1:0] ST_MAB   = 2'd2;
  localparam logic [1:0] ST_SLOT  = 2'd3;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_n;
  logic [2:0]    data_sel;
  logic [9:0]    slot_idx, slot_idx_n;
  logic [9:0]    slots_reg, slots_q;
  logic [7:0]    cur_byte, byte_n, fetch_byte;
  logic [7:0]    start_code, start_code_q;
  logic          ctrl_en, ctrl_oneshot;
  logic          start_frame, frame_end, fetch, tx_n;
  logic [15:0]   frame_cnt;
  logic [7:0]    mem [0:511];
  logic          we_ctrl, we_status, we_slots, we_ram, sel_ram;
  logic [31:0]   rd_mux;
  logic          irq_en_bit, done_bit;

  assign sel_ram   = (CSR_A[13:9] == 5'b00001);
  assign we_ctrl   = CSR_WE && (CSR_A == 14'h000);
  assign we_status = CSR_WE && (CSR_A == 14'h001);
  assign we_slots  = CSR_WE && (CSR_A == 14'h002);
  assign we_ram    = CSR_WE && sel_ram;

  always_comb begin
    rd_mux = 32'h0;
    if (sel_ram) begin
      rd_mux = {24'h0, mem[CSR_A[8:0]]};
    end else begin
      case (CSR_A)
        14'h000: rd_mux = {16'h0, start_code, 5'h0, irq_en_bit, ctrl_oneshot, ctrl_en};
        14'h001: rd_mux = {frame_cnt, 13'h0, done_bit, (state == ST_BREAK), (state != ST_IDLE)};
        14'h002: rd_mux = {22'h0, slots_reg};
        default: rd_mux = 32'h0;
      endcase
    end
  end

  // Frame sequencing; a pending EN or ONESHOT at the end of a frame chains straight into the next break.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_idx;
    slot_idx_n  = slot_idx;
    byte_n      = cur_byte;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    fetch       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en || ctrl_oneshot) begin
          start_frame = 1'b1;
          state_n     = ST_BREAK;
          cnt_n       = '0;
          slot_idx_n  = 10'd0;
        end
      end
      ST_BREAK: begin
        if (cnt == BRK_LAST) begin
          state_n = ST_MAB;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_MAB: begin
        if (cnt == MAB_LAST) begin
          state_n = ST_SLOT;
          cnt_n   = '0;
          bit_n   = 4'd0;
          byte_n  = start_code_q;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (bit_idx == 4'd10) begin
            if (slot_idx == slots_q) begin
              frame_end = 1'b1;
              if (ctrl_en || ctrl_oneshot) begin
                start_frame = 1'b1;
                state_n     = ST_BREAK;
                slot_idx_n  = 10'd0;
              end else begin
                state_n = ST_IDLE;
              end
            end else begin
              slot_idx_n = slot_idx + 10'd1;
              bit_n      = 4'd0;
              byte_n     = fetch_byte;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
            fetch = (bit_idx == 4'd9);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    endcase

    data_sel = bit_n[2:0] - 3'd1;
    case (state_n)
      ST_BREAK: tx_n = 1'b0;
      ST_SLOT: begin
        if (bit_n == 4'd0)      tx_n = 1'b0;
        else if (bit_n <= 4'd8) tx_n = byte_n[data_sel];
        else                    tx_n = 1'b1;
      end
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      slot_idx <= 10'd0;
      cur_byte <= 8'h0;
      DMX_TX   <= 1'b1;
      DMX_DE   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      slot_idx <= slot_idx_n;
      cur_byte <= byte_n;
      DMX_TX   <= tx_n;
      DMX_DE   <= (state_n != ST_IDLE);
    end
  end

  // Frame parameters are snapshotted at frame start so mid-frame writes only affect the next frame.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      CSR_DR       <= 32'h0;
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      start_code   <= 8'h0;
      slots_reg    <= 10'd512;
      slots_q      <= 10'd512;
      start_code_q <= 8'h0;
      frame_cnt    <= 16'h0;
    end else begin
      CSR_DR       <= rd_mux;
      ctrl_oneshot <= (ctrl_oneshot && !start_frame) || (we_ctrl && CSR_DW[1]);
      if (we_ctrl) begin
        ctrl_en    <= CSR_DW[0];
        start_code <= CSR_DW[15:8];
      end
      if (we_slots) begin
        if (CSR_DW == 32'd0)        slots_reg <= 10'd1;
        else if (CSR_DW > 32'd512)  slots_reg <= 10'd512;
        else                        slots_reg <= CSR_DW[9:0];
      end
      if (start_frame) begin
        start_code_q <= start_code;
        slots_q      <= slots_reg;
      end
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Universe buffer: registered TX read returns the pre-write byte on a same-cycle collision.
  always_ff @(posedge PCLK) begin
    if (we_ram) mem[CSR_A[8:0]] <= CSR_DW[7:0];
    if (fetch)  fetch_byte <= mem[slot_idx[8:0]];
  end

`ifdef DMX_TX_IRQ_EN
  logic irq_en, done;
  assign irq_en_bit = irq_en;
  assign done_bit   = done;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      IRQ    <= 1'b0;
    end else begin
      if (we_ctrl) irq_en <= CSR_DW[2];
      if (frame_end)                   done <= 1'b1;
      else if (we_status && CSR_DW[2]) done <= 1'b0;
      IRQ <= done && irq_en;
    end
  end
`else
  assign irq_en_bit = 1'b0;
  assign done_bit   = 1'b0;
`endif

endmodule

// File: tb/tb_dmx_tx_csr.sv
// Directed bench for dmx_tx_csr: CSR register table, frame waveform, EN stop, async reset, optional IRQ.
module tb_dmx_tx_csr;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [13:0] CSR_A;
  logic        CSR_WE;
  logic [31:0] CSR_DW;
  logic [31:0] CSR_DR;
  logic        DMX_TX;
  logic        DMX_DE;
`ifdef DMX_TX_IRQ_EN
  logic        IRQ;
  localparam logic [31:0] CTRL_EXP = 32'h0000_AB04;
`else
  localparam logic [31:0] CTRL_EXP = 32'h0000_AB00;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [31];
  logic exp_line [232];

  always #5 PCLK = ~PCLK;

  dmx_tx_csr #(.CLK_DIV(4), .BREAK_BITS(22), .MAB_BITS(3)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .CSR_A  (CSR_A),
    .CSR_WE (CSR_WE),
    .CSR_DW (CSR_DW),
    .CSR_DR (CSR_DR),
    .DMX_TX (DMX_TX),
    .DMX_DE (DMX_DE)
`ifdef DMX_TX_IRQ_EN
    ,
    .IRQ    (IRQ)
`endif
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    CSR_A  = a;
    CSR_DW = d;
    CSR_WE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    CSR_WE = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    CSR_A  = a;
    CSR_WE = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    d = CSR_DR;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    if (v.we) begin
      csr_write(v.addr, v.data);
    end else begin
      csr_read(v.addr, rd);
      check_output($sformatf("vec%0d_rd_%03h", idx, v.addr), rd, v.exp);
    end
  endtask

  task automatic wait_de(input logic level, input int budget, input string name);
    int n = 0;
    while (DMX_DE !== level && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check_output(name, {31'h0, DMX_DE}, {31'h0, level});
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  frame_bytes [3];
    int p;
    int cnt;

    vecs[0]  = '{1'b0, 14'h002, 32'h0,          32'h0000_0200};
    vecs[1]  = '{1'b0, 14'h001, 32'h0,          32'h0};
    vecs[2]  = '{1'b0, 14'h000, 32'h0,          32'h0};
    vecs[3]  = '{1'b1, 14'h205, 32'h1234_56A5,  32'h0};
    vecs[4]  = '{1'b0, 14'h205, 32'h0,          32'h0000_00A5};
    vecs[5]  = '{1'b1, 14'h002, 32'h0,          32'h0};
    vecs[6]  = '{1'b0, 14'h002, 32'h0,          32'h0000_0001};
    vecs[7]  = '{1'b1, 14'h002, 32'd1000,       32'h0};
    vecs[8]  = '{1'b0, 14'h002, 32'h0,          32'h0000_0200};
    vecs[9]  = '{1'b1, 14'h002, 32'd5,          32'h0};
    vecs[10] = '{1'b0, 14'h002, 32'h0,          32'h0000_0005};
    vecs[11] = '{1'b1, 14'h002, 32'd513,        32'h0};
    vecs[12] = '{1'b0, 14'h002, 32'h0,          32'h0000_0200};
    vecs[13] = '{1'b1, 14'h003, 32'hFFFF_FFFF,  32'h0};
    vecs[14] = '{1'b0, 14'h003, 32'h0,          32'h0};
    vecs[15] = '{1'b0, 14'h100, 32'h0,          32'h0};
    vecs[16] = '{1'b1, 14'h001, 32'hFFFF_FFFF,  32'h0};
    vecs[17] = '{1'b0, 14'h001, 32'h0,          32'h0};
    vecs[18] = '{1'b1, 14'h000, 32'hFFFF_AB0C,  32'h0};
    vecs[19] = '{1'b0, 14'h000, 32'h0,          CTRL_EXP};
    vecs[20] = '{1'b1, 14'h000, 32'h0,          32'h0};
    vecs[21] = '{1'b1, 14'h3FF, 32'h0000_01FF,  32'h0};
    vecs[22] = '{1'b0, 14'h3FF, 32'h0,          32'h0000_00FF};
    vecs[23] = '{1'b0, 14'h205, 32'h0,          32'h0000_00A5};
    vecs[24] = '{1'b1, 14'h002, 32'd2,          32'h0};
    vecs[25] = '{1'b1, 14'h200, 32'h0000_0055,  32'h0};
    vecs[26] = '{1'b1, 14'h201, 32'h0000_0081,  32'h0};
    vecs[27] = '{1'b0, 14'h201, 32'h0,          32'h0000_0081};
    vecs[28] = '{1'b0, 14'h1205, 32'h0,         32'h0};
    vecs[29] = '{1'b1, 14'h1205, 32'h0000_0077, 32'h0};
    vecs[30] = '{1'b0, 14'h205, 32'h0,          32'h0000_00A5};

    // Expected line for SLOTS=2, start code 0xCC, data 0x55 0x81 at 4 clocks per bit.
    frame_bytes[0] = 8'hCC;
    frame_bytes[1] = 8'h55;
    frame_bytes[2] = 8'h81;
    p = 0;
    for (int i = 0; i < 88; i++) begin exp_line[p] = 1'b0; p++; end
    for (int i = 0; i < 12; i++) begin exp_line[p] = 1'b1; p++; end
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 4; i++) begin exp_line[p] = 1'b0; p++; end
      for (int b = 0; b < 8; b++)
        for (int i = 0; i < 4; i++) begin exp_line[p] = frame_bytes[s][b]; p++; end
      for (int i = 0; i < 8; i++) begin exp_line[p] = 1'b1; p++; end
    end

    PRESET = 1'b1;
    CSR_A  = 14'h0;
    CSR_WE = 1'b0;
    CSR_DW = 32'h0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check_output("reset_de_tx", {30'h0, DMX_DE, DMX_TX}, 32'h1);
    check_output("reset_csr_dr", CSR_DR, 32'h0);

    for (int i = 0; i < 31; i++) apply_stimulus(vecs[i], i);

    // One-shot frame waveform.
    csr_write(14'h000, 32'h0000_CC02);
    wait_de(1'b1, 20, "frame1_de_rise");
    for (int k = 0; k < 232; k++) begin
      check_output($sformatf("frame_line_%0d", k), {30'h0, DMX_DE, DMX_TX}, {30'h0, 1'b1, exp_line[k]});
      @(negedge PCLK);
    end
    check_output("frame_end_idle", {30'h0, DMX_DE, DMX_TX}, 32'h1);
    csr_read(14'h001, rd);
    check_output("frame_cnt_1", rd & 32'hFFFF_0003, 32'h0001_0000);
    csr_read(14'h000, rd);
    check_output("oneshot_cleared", rd, 32'h0000_CC00);

    // Continuous frames, EN cleared during slot 1 of frame 2.
    apply_reset();
    csr_write(14'h002, 32'd2);
    csr_write(14'h000, 32'h0000_CC01);
    wait_de(1'b1, 20, "cont_de_rise");
    cnt = 0;
    for (int k = 1; k < 390; k++) begin
      @(negedge PCLK);
      if (DMX_DE !== 1'b1) cnt++;
    end
    check_output("cont_no_gap", cnt, 0);
    csr_write(14'h000, 32'h0000_CC00);
    wait_de(1'b0, 200, "cont_stop");
    csr_read(14'h001, rd);
    check_output("frame_cnt_2", rd & 32'hFFFF_0003, 32'h0002_0000);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge PCLK);
      if (DMX_DE !== 1'b0) cnt++;
    end
    check_output("no_third_break", cnt, 0);

    // Asynchronous reset during the start code slot.
    csr_write(14'h000, 32'h0000_CC02);
    wait_de(1'b1, 20, "rst_de_rise");
    repeat (105) @(negedge PCLK);
    check_output("pre_reset_tx", {31'h0, DMX_TX}, 32'h0);
    #2 PRESET = 1'b1;
    #1 check_output("async_reset_out", {30'h0, DMX_DE, DMX_TX}, 32'h1);
    @(negedge PCLK);
    PRESET = 1'b0;
    csr_read(14'h000, rd);
    check_output("post_reset_ctrl", rd, 32'h0);
    csr_read(14'h001, rd);
    check_output("post_reset_status", rd, 32'h0);
    csr_read(14'h002, rd);
    check_output("post_reset_slots", rd, 32'h0000_0200);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (DMX_DE !== 1'b0) cnt++;
    end
    check_output("post_reset_idle", cnt, 0);

`ifdef DMX_TX_IRQ_EN
    csr_write(14'h002, 32'd2);
    csr_write(14'h000, 32'h0000_CC06);
    wait_de(1'b1, 20, "irq_de_rise");
    check_output("irq_low_in_frame", {31'h0, IRQ}, 32'h0);
    wait_de(1'b0, 300, "irq_frame_end");
    repeat (3) @(negedge PCLK);
    check_output("irq_set", {31'h0, IRQ}, 32'h1);
    csr_read(14'h001, rd);
    check_output("done_sticky", rd & 32'h4, 32'h4);
    csr_write(14'h001, 32'h0000_0004);
    repeat (2) @(negedge PCLK);
    check_output("irq_cleared", {31'h0, IRQ}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
